// File: rtl/sad_search_ctrl.sv
// SAD motion-search controller: kicks the SAD engine, waits with a watchdog,
// then scans the SAD result memory for the minimum cost and its index.
module sad_search_ctrl (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Start,
  input  logic [7:0]  Num_Cand,
  output logic        Sad_Go,
  input  logic        Sad_Done,
  output logic [6:0]  C_Addr,
  output logic        C_En,
  input  logic [31:0] C_Rd_Data,
  output logic        Busy,
  output logic        Done,
  output logic        Error,
  output logic [31:0] Best_Sad,
  output logic [6:0]  Best_Idx
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    KICK  = 3'd1,
    WAIT  = 3'd2,
    SCAN  = 3'd3,
    DRAIN = 3'd4,
    FIN   = 3'd5
  } state_t;

  state_t      state_r;
  logic [7:0]  n_r;
  logic [11:0] wdog_r;
  logic [6:0]  rd_idx_r;
  logic [31:0] min_sad_r;
  logic [6:0]  min_idx_r;
  logic        cmp_vld_r;
  logic [6:0]  cmp_idx_r;

  logic [31:0] min_sad_s;
  logic [6:0]  min_idx_s;
  logic        last_s;

  assign last_s = ({1'b0, rd_idx_r} == (n_r - 8'd1));

  // Running-minimum update; strict less-than keeps the lower index on ties.
  always_comb begin
    min_sad_s = min_sad_r;
    min_idx_s = min_idx_r;
    if (cmp_vld_r && (C_Rd_Data < min_sad_r)) begin
      min_sad_s = C_Rd_Data;
      min_idx_s = cmp_idx_r;
    end else begin
      min_sad_s = min_sad_r;
      min_idx_s = min_idx_r;
    end
  end

  // Search FSM with all outputs registered.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_r   <= IDLE;
      n_r       <= 8'd0;
      wdog_r    <= 12'd0;
      rd_idx_r  <= 7'd0;
      min_sad_r <= 32'hFFFF_FFFF;
      min_idx_r <= 7'd0;
      cmp_vld_r <= 1'b0;
      cmp_idx_r <= 7'd0;
      Sad_Go    <= 1'b0;
      C_En      <= 1'b0;
      C_Addr    <= 7'd0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      Error     <= 1'b0;
      Best_Sad  <= 32'hFFFF_FFFF;
      Best_Idx  <= 7'd0;
    end else begin
      // Read data returns one cycle after C_En, so the compare lags the read.
      cmp_vld_r <= C_En;
      cmp_idx_r <= C_Addr;
      min_sad_r <= min_sad_s;
      min_idx_r <= min_idx_s;
      case (state_r)
        IDLE: begin
          if (Start && (Num_Cand != 8'd0)) begin
            n_r     <= (Num_Cand > 8'd128) ? 8'd128 : Num_Cand;
            Error   <= 1'b0;
            Busy    <= 1'b1;
            Sad_Go  <= 1'b1;
            state_r <= KICK;
          end else begin
            state_r <= IDLE;
          end
        end
        KICK: begin
          Sad_Go    <= 1'b0;
          wdog_r    <= 12'd0;
          min_sad_r <= 32'hFFFF_FFFF;
          min_idx_r <= 7'd0;
          state_r   <= WAIT;
        end
        WAIT: begin
          if (Sad_Done) begin
            rd_idx_r <= 7'd0;
            C_En     <= 1'b1;
            C_Addr   <= 7'd0;
            state_r  <= SCAN;
          end else if (wdog_r == 12'd4095) begin
            Error    <= 1'b1;
            Done     <= 1'b1;
            Best_Sad <= 32'hFFFF_FFFF;
            Best_Idx <= 7'd0;
            state_r  <= FIN;
          end else begin
            wdog_r   <= wdog_r + 12'd1;
          end
        end
        SCAN: begin
          if (last_s) begin
            C_En    <= 1'b0;
            C_Addr  <= 7'd0;
            state_r <= DRAIN;
          end else begin
            rd_idx_r <= rd_idx_r + 7'd1;
            C_Addr   <= rd_idx_r + 7'd1;
            C_En     <= 1'b1;
          end
        end
        DRAIN: begin
          // The final compare happens on this edge, so load the bypassed minimum.
          Best_Sad <= min_sad_s;
          Best_Idx <= min_idx_s;
          Done     <= 1'b1;
          state_r  <= FIN;
        end
        FIN: begin
          Done    <= 1'b0;
          Busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          Sad_Go  <= 1'b0;
          C_En    <= 1'b0;
          Done    <= 1'b0;
          Busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sad_search_ctrl.sv
// Bench for sad_search_ctrl: a timeline model predicts every output each cycle
// from the start/done cycles and the result memory contents.
module tb_sad_search_ctrl;

  localparam int BIG = 32'h3FFF_FFFF;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        Start = 1'b0;
  logic [7:0]  Num_Cand = 8'd0;
  logic        Sad_Go;
  logic        Sad_Done = 1'b0;
  logic [6:0]  C_Addr;
  logic        C_En;
  logic [31:0] C_Rd_Data = 32'd0;
  logic        Busy, Done, Error;
  logic [31:0] Best_Sad;
  logic [6:0]  Best_Idx;

  sad_search_ctrl dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Num_Cand(Num_Cand),
    .Sad_Go(Sad_Go), .Sad_Done(Sad_Done), .C_Addr(C_Addr), .C_En(C_En),
    .C_Rd_Data(C_Rd_Data), .Busy(Busy), .Done(Done), .Error(Error),
    .Best_Sad(Best_Sad), .Best_Idx(Best_Idx)
  );

  always #5 Clk = ~Clk;

  logic [31:0] mem [128];
  int cyc = 0;

  // Edge counter: outputs seen at negedge with cyc==e reflect edge e.
  always @(posedge Clk) cyc <= cyc + 1;

  // Result memory: one-cycle read latency, zero when not enabled.
  always @(posedge Clk) begin
    if (C_En) C_Rd_Data <= mem[C_Addr];
    else      C_Rd_Data <= 32'd0;
  end

  // Timeline model of the current search.
  int s_cyc = BIG, w_cyc = BIG, n_m = 0, done_cyc = BIG, abort_cyc = 0;
  logic [31:0] old_sad = 32'hFFFF_FFFF, new_sad = 32'hFFFF_FFFF;
  logic [6:0]  old_idx = 7'd0, new_idx = 7'd0;
  logic        old_err = 1'b0, new_err = 1'b0;
  bit          check_en = 1'b0;

  // Literal expectations handed to the compare process.
  int lit_seq = 0, lit_done = 0, cen_cnt = 0, cen_base = 0;
  logic [31:0] lit_sad;
  logic [6:0]  lit_idx;
  logic        lit_err, lit_busy;
  int          lit_cen;

  int vecs = 0, miss = 0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    vecs = vecs + 1;
    if (act !== exp) begin
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
      miss = miss + 1;
    end
  endfunction

  // Compare process: model vs DUT every cycle, plus pending literal checks.
  always @(negedge Clk) begin : cmp
    logic [50:0] e_v, a_v;
    bit ex_cen, fin;
    if (check_en) begin
      if (cyc >= abort_cyc) begin
        e_v = {3'b000, 7'd0, 2'b00, 32'hFFFF_FFFF, 7'd0};
      end else begin
        ex_cen = (cyc >= w_cyc) && (cyc < w_cyc + n_m);
        fin = (cyc >= done_cyc);
        e_v = {cyc == s_cyc, (cyc >= s_cyc) && (cyc <= done_cyc), ex_cen,
               ex_cen ? 7'(cyc - w_cyc) : 7'd0, cyc == done_cyc,
               fin ? new_err : ((cyc >= s_cyc) ? 1'b0 : old_err),
               fin ? new_sad : old_sad, fin ? new_idx : old_idx};
      end
      a_v = {Sad_Go, Busy, C_En, (C_En ? C_Addr : 7'd0), Done, Error, Best_Sad, Best_Idx};
      chk("outputs{go,busy,cen,addr,done,err,sad,idx}", 64'(a_v), 64'(e_v));
    end
    if (lit_seq != lit_done) begin
      chk("best_sad", 64'(Best_Sad), 64'(lit_sad));
      chk("best_idx", 64'(Best_Idx), 64'(lit_idx));
      chk("error", 64'(Error), 64'(lit_err));
      chk("busy", 64'(Busy), 64'(lit_busy));
      chk("c_en_count", 64'(cen_cnt - cen_base), 64'(lit_cen));
      lit_done <= lit_seq;
    end
    if (C_En === 1'b1) cen_cnt <= cen_cnt + 1;
  end

  task automatic lit(input logic [31:0] sad, input logic [6:0] idx, input logic err,
                     input logic busy, input int ncen);
    lit_sad = sad; lit_idx = idx; lit_err = err; lit_busy = busy; lit_cen = ncen;
    lit_seq = lit_seq + 1;
    @(negedge Clk);
    #1;
  endtask

  // dly: Sad_Done sampled dly edges after Sad_Go (negative = never).
  task automatic run(input logic [7:0] nc, input int dly, input bit noise, input bit abort);
    @(posedge Clk);
    #1;
    if (abort_cyc != BIG) begin
      new_sad = 32'hFFFF_FFFF; new_idx = 7'd0; new_err = 1'b0; abort_cyc = BIG;
    end
    old_sad = new_sad; old_idx = new_idx; old_err = new_err;
    cen_base = cen_cnt;
    s_cyc = cyc + 1;
    n_m = (nc > 8'd128) ? 128 : int'(nc);
    new_sad = 32'hFFFF_FFFF;
    new_idx = 7'd0;
    if (dly >= 0) begin
      w_cyc = s_cyc + dly;
      done_cyc = w_cyc + n_m + 1;
      new_err = 1'b0;
      for (int i = 0; i < n_m; i++) begin
        if (mem[i] < new_sad) begin
          new_sad = mem[i];
          new_idx = 7'(i);
        end
      end
    end else begin
      w_cyc = BIG;
      done_cyc = s_cyc + 4097;
      new_err = 1'b1;
    end
    Start = 1'b1;
    Num_Cand = nc;
    while (cyc < done_cyc + 1) begin
      @(posedge Clk);
      #1;
      if (abort && (cyc + 1 == w_cyc + 2)) begin
        Rst = 1'b1;
        abort_cyc = cyc + 1;
        Start = 1'b0;
        Sad_Done = 1'b0;
        break;
      end
      Start = noise && ((cyc + 1 == s_cyc + 4) || (cyc + 1 == w_cyc + 1));
      Sad_Done = (cyc + 1 == w_cyc) || (noise && (cyc + 1 == w_cyc + 2));
      Num_Cand = noise ? 8'd9 : nc;
    end
    Start = 1'b0;
    Sad_Done = 1'b0;
    if (abort) begin
      @(posedge Clk);
      #1;
      @(posedge Clk);
      #1;
      Rst = 1'b0;
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'hFFFF_FFFF;
    repeat (3) @(posedge Clk);
    #1;
    check_en = 1'b1;
    Rst = 1'b0;
    lit(32'hFFFF_FFFF, 7'd0, 1'b0, 1'b0, 0);

    // Num_Cand=0 must not start a search
    @(posedge Clk);
    #1;
    Start = 1'b1;
    Num_Cand = 8'd0;
    repeat (3) @(posedge Clk);
    #1;
    Start = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    lit(32'hFFFF_FFFF, 7'd0, 1'b0, 1'b0, 0);

    // Basic 4-candidate search with a tie
    mem[0] = 32'd500; mem[1] = 32'd120; mem[2] = 32'd120; mem[3] = 32'd900;
    run(8'd4, 10, 1'b0, 1'b0);
    lit(32'd120, 7'd1, 1'b0, 1'b0, 4);

    // Stray Start / Sad_Done while busy
    mem[0] = 32'd7; mem[1] = 32'd3; mem[2] = 32'd3; mem[3] = 32'd9;
    run(8'd4, 10, 1'b1, 1'b0);
    lit(32'd3, 7'd1, 1'b0, 1'b0, 4);

    // Num_Cand above 128 clamps; minimum at the last address
    for (int i = 0; i < 127; i++) mem[i] = 32'd1000 + 32'(i);
    mem[127] = 32'd7;
    run(8'd200, 3, 1'b0, 1'b0);
    lit(32'd7, 7'd127, 1'b0, 1'b0, 128);

    // All entries at max: nothing strictly less, index stays 0; earliest Sad_Done
    for (int i = 0; i < 128; i++) mem[i] = 32'hFFFF_FFFF;
    run(8'd128, 2, 1'b0, 1'b0);
    lit(32'hFFFF_FFFF, 7'd0, 1'b0, 1'b0, 128);

    // Watchdog expiry
    run(8'd5, -1, 1'b0, 1'b0);
    lit(32'hFFFF_FFFF, 7'd0, 1'b1, 1'b0, 0);

    // Sad_Done on the expiry cycle wins
    mem[0] = 32'd9; mem[1] = 32'd8;
    run(8'd2, 4097, 1'b0, 1'b0);
    lit(32'd8, 7'd1, 1'b0, 1'b0, 2);

    // Reset during SCAN aborts, then a clean single-candidate search
    mem[0] = 32'd50; mem[1] = 32'd40; mem[2] = 32'd30; mem[3] = 32'd20;
    run(8'd4, 3, 1'b0, 1'b1);
    lit(32'hFFFF_FFFF, 7'd0, 1'b0, 1'b0, 2);
    mem[0] = 32'd42;
    run(8'd1, 4, 1'b0, 1'b0);
    lit(32'd42, 7'd0, 1'b0, 1'b0, 1);

    @(negedge Clk);
    @(negedge Clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
